// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, WB write-through
// of register-file reads, flush/stall handling and a saturating bubble counter.
module id_ex_reg #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic [31:0]       id_rs1_val,
  input  logic [31:0]       id_rs2_val,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        id_rd_addr,
  input  logic              id_is_load,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd_addr,
  input  logic [31:0]       wb_rd_val,
  input  logic              ex_flush,
  input  logic              stall_in,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_is_load,
  output logic [4:0]        ex_rd_addr,
  output logic [4:0]        ex_rs1_addr,
  output logic [4:0]        ex_rs2_addr,
  output logic [31:0]       ex_rs1_val,
  output logic [31:0]       ex_rs2_val,
  output logic              id_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              is_load_q, is_load_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [4:0]        rs1_addr_q, rs1_addr_d;
  logic [4:0]        rs2_addr_q, rs2_addr_d;
  logic [31:0]       rs1_val_q, rs1_val_d;
  logic [31:0]       rs2_val_q, rs2_val_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic load_use;
  logic do_hold;
  logic do_capture;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // x0 always reads as zero; otherwise a same-cycle WB write wins over the stale RF read.
  function automatic logic [31:0] rs_fwd(input logic [4:0]  addr,
                                         input logic [31:0] rf_val,
                                         input logic        we,
                                         input logic [4:0]  w_addr,
                                         input logic [31:0] w_val);
    if (addr == 5'd0)                 return 32'd0;
    else if (we && (w_addr == addr))  return w_val;
    else                              return rf_val;
  endfunction

  assign load_use = valid_q & is_load_q & (rd_addr_q != 5'd0) & id_valid &
                    ((id_uses_rs1 & (id_rs1_addr == rd_addr_q)) |
                     (id_uses_rs2 & (id_rs2_addr == rd_addr_q)));

  assign id_stall   = (load_use | stall_in) & ~ex_flush;
  assign do_hold    = ~rst & ~ex_flush & stall_in;
  assign do_capture = ~rst & ~ex_flush & ~stall_in & ~load_use & id_valid;

  always_comb begin
    valid_d    = 1'b0;
    pc_d       = '0;
    imm_d      = '0;
    ctrl_d     = '0;
    is_load_d  = 1'b0;
    rd_addr_d  = '0;
    rs1_addr_d = '0;
    rs2_addr_d = '0;
    rs1_val_d  = '0;
    rs2_val_d  = '0;
    cnt_d      = cnt_q;
    if (rst) begin
      cnt_d = '0;
    end else if (!ex_flush && !stall_in && load_use) begin
      cnt_d = sat_inc(cnt_q);
    end
    if (do_hold) begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      imm_d      = imm_q;
      ctrl_d     = ctrl_q;
      is_load_d  = is_load_q;
      rd_addr_d  = rd_addr_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rs1_val_d  = rs1_val_q;
      rs2_val_d  = rs2_val_q;
    end else if (do_capture) begin
      valid_d    = 1'b1;
      pc_d       = id_pc;
      imm_d      = id_imm;
      ctrl_d     = id_ctrl;
      is_load_d  = id_is_load;
      rd_addr_d  = id_rd_addr;
      rs1_addr_d = id_rs1_addr;
      rs2_addr_d = id_rs2_addr;
      rs1_val_d  = rs_fwd(id_rs1_addr, id_rs1_val, wb_we, wb_rd_addr, wb_rd_val);
      rs2_val_d  = rs_fwd(id_rs2_addr, id_rs2_val, wb_we, wb_rd_addr, wb_rd_val);
    end
  end

  always_ff @(posedge clk) begin
    valid_q    <= valid_d;
    pc_q       <= pc_d;
    imm_q      <= imm_d;
    ctrl_q     <= ctrl_d;
    is_load_q  <= is_load_d;
    rd_addr_q  <= rd_addr_d;
    rs1_addr_q <= rs1_addr_d;
    rs2_addr_q <= rs2_addr_d;
    rs1_val_q  <= rs1_val_d;
    rs2_val_q  <= rs2_val_d;
    cnt_q      <= cnt_d;
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_imm      = imm_q;
  assign ex_ctrl     = ctrl_q;
  assign ex_is_load  = is_load_q;
  assign ex_rd_addr  = rd_addr_q;
  assign ex_rs1_addr = rs1_addr_q;
  assign ex_rs2_addr = rs2_addr_q;
  assign ex_rs1_val  = rs1_val_q;
  assign ex_rs2_val  = rs2_val_q;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: capture, load-use, WB bypass, hold, flush,
// counter saturation (CNT_W=2) and reset behaviour.
module tb_id_ex_reg;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [31:0]       id_pc, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [4:0]        id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0]       id_rs1_val, id_rs2_val;
  logic              id_uses_rs1, id_uses_rs2, id_is_load;
  logic              wb_we;
  logic [4:0]        wb_rd_addr;
  logic [31:0]       wb_rd_val;
  logic              ex_flush, stall_in;
  logic              ex_valid, ex_is_load, id_stall;
  logic [31:0]       ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [4:0]        ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
  logic [CNT_W-1:0]  bubble_cnt;

  int checks   = 0;
  int failures = 0;

  id_ex_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd_addr(id_rd_addr), .id_is_load(id_is_load),
    .wb_we(wb_we), .wb_rd_addr(wb_rd_addr), .wb_rd_val(wb_rd_val),
    .ex_flush(ex_flush), .stall_in(stall_in),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .id_stall(id_stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [31:0] v1, input logic u1,
                        input logic [4:0] rs2, input logic [31:0] v2, input logic u2,
                        input logic [4:0] rd, input logic ld);
    id_valid = v;  id_pc = pc; id_imm = pc + 32'h1000; id_ctrl = pc[15:0] ^ 16'hA5A5;
    id_rs1_addr = rs1; id_rs1_val = v1; id_uses_rs1 = u1;
    id_rs2_addr = rs2; id_rs2_val = v2; id_uses_rs2 = u2;
    id_rd_addr = rd; id_is_load = ld;
  endtask

  initial begin
    rst = 1'b1; ex_flush = 1'b0; stall_in = 1'b0;
    wb_we = 1'b0; wb_rd_addr = '0; wb_rd_val = '0;
    set_id(1'b1, 32'h50, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 1'b1);
    step(); step();
    check("rst_valid", ex_valid, 0);
    check("rst_pc", ex_pc, 0);
    check("rst_ctrl", ex_ctrl, 0);
    check("rst_cnt", bubble_cnt, 0);
    stall_in = 1'b1; #1;
    check("rst_stall_follows", id_stall, 1);
    stall_in = 1'b0; #1;
    check("rst_stall_low", id_stall, 0);

    // Plain capture
    rst = 1'b0;
    set_id(1'b1, 32'h100, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 1'b0);
    step();
    check("cap_valid", ex_valid, 1);
    check("cap_pc", ex_pc, 32'h100);
    check("cap_imm", ex_imm, 32'h1100);
    check("cap_ctrl", ex_ctrl, 32'hA4A5);
    check("cap_rs1_addr", ex_rs1_addr, 5);
    check("cap_rs2_addr", ex_rs2_addr, 6);
    check("cap_rd", ex_rd_addr, 7);
    check("cap_rs1_val", ex_rs1_val, 32'h55);
    check("cap_rs2_val", ex_rs2_val, 32'h66);

    // Load then dependent: one bubble, then capture with WB write-through
    set_id(1'b1, 32'h104, 5'd1, 32'h10, 1'b1, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1);
    #1 check("lu_no_stall_yet", id_stall, 0);
    step();
    check("lu_ex_is_load", ex_is_load, 1);
    set_id(1'b1, 32'h108, 5'd5, 32'h99, 1'b1, 5'd0, 32'h0, 1'b0, 5'd8, 1'b0);
    #1 check("lu_stall", id_stall, 1);
    step();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_rs1", ex_rs1_addr, 0);
    check("lu_bubble_rd", ex_rd_addr, 0);
    check("lu_bubble_pc", ex_pc, 0);
    check("lu_cnt", bubble_cnt, 1);
    check("lu_stall_released", id_stall, 0);
    wb_we = 1'b1; wb_rd_addr = 5'd5; wb_rd_val = 32'h77;
    step();
    check("lu_dep_valid", ex_valid, 1);
    check("lu_dep_pc", ex_pc, 32'h108);
    check("lu_dep_rs1_wb", ex_rs1_val, 32'h77);
    check("lu_cnt_after", bubble_cnt, 1);

    // WB bypass on rs2; rs1=x0 must read zero
    set_id(1'b1, 32'h10C, 5'd0, 32'hDEAD, 1'b0, 5'd9, 32'h11, 1'b0, 5'd0, 1'b0);
    wb_we = 1'b1; wb_rd_addr = 5'd9; wb_rd_val = 32'hAB;
    step();
    check("wb_rs2_bypass", ex_rs2_val, 32'hAB);
    check("wb_rs1_x0", ex_rs1_val, 0);
    wb_rd_addr = 5'd0;
    step();
    check("wb_x0_no_bypass", ex_rs2_val, 32'h11);
    check("wb_x0_rs1", ex_rs1_val, 0);
    wb_we = 1'b0;

    // Hold for three cycles with changing ID
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'h200 + 32'(4 * i), 5'd2, 32'h2, 1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 1'b0);
      #1 check("hold_stall", id_stall, 1);
      step();
      check("hold_pc", ex_pc, 32'h10C);
      check("hold_rs2_val", ex_rs2_val, 32'h11);
    end
    stall_in = 1'b0;
    set_id(1'b1, 32'h20C, 5'd2, 32'h2, 1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 1'b0);
    step();
    check("release_pc", ex_pc, 32'h20C);
    check("release_cnt", bubble_cnt, 1);

    // Flush wins over stall_in and load_use
    set_id(1'b1, 32'h300, 5'd1, 32'h1, 1'b1, 5'd0, 32'h0, 1'b0, 5'd3, 1'b1);
    step();
    set_id(1'b1, 32'h304, 5'd3, 32'h3, 1'b1, 5'd0, 32'h0, 1'b0, 5'd6, 1'b0);
    stall_in = 1'b1; ex_flush = 1'b1;
    #1 check("flush_stall_low", id_stall, 0);
    step();
    check("flush_valid", ex_valid, 0);
    check("flush_is_load", ex_is_load, 0);
    check("flush_cnt", bubble_cnt, 1);
    stall_in = 1'b0; ex_flush = 1'b0;

    // id_valid=0 loads a bubble
    set_id(1'b0, 32'h400, 5'd7, 32'h7, 1'b1, 5'd8, 32'h8, 1'b1, 5'd9, 1'b1);
    step();
    check("inval_valid", ex_valid, 0);
    check("inval_pc", ex_pc, 0);

    // Saturation from zero: 1,2,3,3,3
    rst = 1'b1; step(); rst = 1'b0;
    check("sat_reset", bubble_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      set_id(1'b1, 32'h500, 5'd1, 32'h1, 1'b1, 5'd0, 32'h0, 1'b0, 5'd4, 1'b1);
      step();
      set_id(1'b1, 32'h504, 5'd0, 32'h0, 1'b0, 5'd4, 32'h4, 1'b1, 5'd5, 1'b0);
      step();
      check("sat_cnt", bubble_cnt, (i < 3) ? i + 1 : 3);
    end

    // Reset in the middle of a load-use stall discards it without counting
    set_id(1'b1, 32'h600, 5'd1, 32'h1, 1'b1, 5'd0, 32'h0, 1'b0, 5'd4, 1'b1);
    step();
    set_id(1'b1, 32'h604, 5'd4, 32'h4, 1'b1, 5'd0, 32'h0, 1'b0, 5'd5, 1'b0);
    #1 check("midrst_stall", id_stall, 1);
    rst = 1'b1;
    step();
    check("midrst_valid", ex_valid, 0);
    check("midrst_cnt", bubble_cnt, 0);
    check("midrst_rd", ex_rd_addr, 0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 16, width of the opaque decoded-control bundle.
REQ-002 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-003 SHALL have ports clk (in, 1, sole clock, rising edge) and rst (in, 1, synchronous active-high reset).
REQ-004 SHALL have id_valid (in, 1), id_pc (in, 32), id_imm (in, 32) and id_ctrl (in, CTRL_W) for the ID-stage instruction.
REQ-005 SHALL have id_rs1_addr and id_rs2_addr (in, 5 each), id_rs1_val and id_rs2_val (in, 32 each, register-file reads), id_uses_rs1 and id_uses_rs2 (in, 1 each), id_rd_addr (in, 5) and id_is_load (in, 1).
REQ-006 SHALL have wb_we (in, 1), wb_rd_addr (in, 5) and wb_rd_val (in, 32) for the register-file write port this cycle.
REQ-007 SHALL have ex_flush (in, 1; taken branch/jump resolved in EX) and stall_in (in, 1; downstream MEM stall).
REQ-008 SHALL have ex_valid (out, 1), ex_pc (out, 32), ex_imm (out, 32), ex_ctrl (out, CTRL_W), ex_is_load (out, 1) and ex_rd_addr (out, 5).
REQ-009 SHALL have ex_rs1_addr and ex_rs2_addr (out, 5 each) and ex_rs1_val and ex_rs2_val (out, 32 each), which feed the EX forwarding unit.
REQ-010 SHALL have id_stall (out, 1; hold PC/IF/ID) and bubble_cnt (out, CNT_W).

Function
REQ-011 All ex_* outputs and bubble_cnt SHALL be registered; id_stall SHALL be combinational.
REQ-012 load_use SHALL = ex_valid & ex_is_load & (ex_rd_addr!=0) & id_valid & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
REQ-013 id_stall SHALL = (load_use | stall_in) & ~ex_flush.
REQ-014 Per-edge priority SHALL be: rst > ex_flush > stall_in > load_use > capture.
REQ-015 On ex_flush, the register SHALL load a bubble.
REQ-016 On stall_in without flush, all ex_* SHALL hold their values.
REQ-017 On load_use without flush or stall_in, the register SHALL load a bubble and bubble_cnt SHALL increment.
REQ-018 A bubble SHALL be: ex_valid=0, ex_is_load=0, ex_ctrl=0, all ex_* addresses=0 and all ex_* values=0, so that downstream forwarding matches only x0 and leaves registers unchanged.
REQ-019 Capture SHALL register the id_* fields; if id_valid=0, a bubble SHALL be loaded instead (1-cycle latency ID->EX).
REQ-020 Capture SHALL apply WB write-through: ex_rsN_val = wb_rd_val if wb_we & wb_rd_addr!=0 & wb_rd_addr==id_rsN_addr, else id_rsN_val, independently for N=1,2.
REQ-021 A captured rsN address of 0 SHALL give ex_rsN_val=0 regardless of the WB or register-file value.
REQ-022 bubble_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap; flush bubbles SHALL NOT be counted.
REQ-023 Simultaneous load_use and ex_flush SHALL produce a flush bubble with id_stall=0.
REQ-024 A load followed by a dependent instruction SHALL stall exactly 1 cycle.

Reset
REQ-025 With rst high at a clock edge, all ex_* outputs SHALL be 0 (bubble) and bubble_cnt SHALL be 0.
REQ-026 While rst is high, id_stall SHALL follow REQ-013 using the post-reset ex_valid=0.
REQ-027 Reset asserted mid-stall SHALL discard the held instruction, with no bubble counted on that edge.

Verification
REQ-028 Capture: id_valid=1, rs1=5, rs2=6, rd=7, pc=0x100, wb_we=0 -> next cycle ex_valid=1, ex_pc=0x100, addresses and values match inputs.
REQ-029 Load-use: EX holds a load with rd=5 and ID uses rs1=5 -> id_stall=1 for one cycle, then a bubble (ex_valid=0, addresses=0), bubble_cnt 0->1, then the dependent instruction is captured.
REQ-030 WB bypass: id_rs2_addr=9, id_rs2_val=0x11, wb_we=1, wb_rd_addr=9, wb_rd_val=0xAB -> ex_rs2_val=0xAB; the same stimulus with wb_rd_addr=0 -> 0x11.
REQ-031 Flush vs stall: ex_flush=1 together with load_use=1 and stall_in=1 -> id_stall=0, next-cycle bubble, bubble_cnt unchanged.
REQ-032 Hold: stall_in=1 for 3 cycles with changing id_* -> ex_* constant throughout; on release, current id_* is captured.
REQ-033 Saturation: with CNT_W=2, 5 load-use bubbles -> bubble_cnt=3; then rst -> 0.
